emul_sql: RTL and testbench
===========================

EMUL_SQL -- requirements
Module: emul_sql

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits and result width at 16 bits.
REQ-002 clock  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising clock edge.
REQ-004 a  input  8  unsigned multiplicand.
REQ-005 b  input  8  unsigned multiplier.
REQ-006 enable  input  1  start request, sampled in IDLE.
REQ-007 x  output  16  unsigned product a*b, registered.
REQ-008 ready  output  1  high when x holds a valid product, registered.
REQ-009 The port declaration order SHALL be x, a, b, clock, enable, reset, ready, so that positional instantiation binds correctly.

Function
REQ-010 The block SHALL compute x = a*b by quarter-squares: x = ((a+b)^2 - (a-b)^2) / 4.
REQ-011 Sum and difference terms:
- s = a+b, 9 bits (max 510).
- d = |a-b|, 8 bits.
REQ-012 The squares SHALL be formed by two iterative shift-add squarers running in parallel, one bit of the squared operand per cycle, LSB first, over 9 iterations.
- s^2 accumulator: 18 bits.
- d^2 accumulator: 16 bits, with d zero-extended to 9 bits.
REQ-013 Combine step: x = (s^2 - d^2) >> 2.
- Subtraction SHALL be 18-bit.
- The result is exact (difference always divisible by 4) and SHALL be truncated to 16 bits without loss.
REQ-014 State machine states: IDLE, LOAD, SQUARE, COMBINE, DONE.
REQ-015 IDLE: ready=0; on a rising edge with enable=1 the state SHALL go to LOAD; otherwise it SHALL stay in IDLE.
REQ-016 LOAD (1 cycle): latch a and b, compute s and d, clear both accumulators and the iteration counter, then go to SQUARE.
REQ-017 SQUARE: 9 cycles, one iteration each; after the 9th iteration the state SHALL go to COMBINE.
REQ-018 COMBINE (1 cycle): register x, set ready=1, go to DONE.
REQ-019 Latency: ready SHALL rise 11 rising edges after, and including, the edge that samples enable=1 in IDLE.
REQ-020 DONE SHALL hold x and ready=1 indefinitely, regardless of enable; only reset leaves DONE.
REQ-021 Operands SHALL be captured only in LOAD; changes on a/b at any other time SHALL NOT affect the result in progress or the held x.
REQ-022 enable deasserting after the start edge SHALL NOT abort the operation.
REQ-023 Boundary values SHALL produce exact results:
- a=0 or b=0 -> x=0.
- a=b -> d=0.
- a<b and a>b -> identical results for swapped operands.
- a=b=255 -> x=65025.

Reset
REQ-024 When reset=0 at a rising edge, the block SHALL set state=IDLE, x=16'h0000, ready=0, and clear all accumulators, counter and operand registers; reset SHALL take priority over enable and all other activity.
REQ-025 Reset asserted mid-operation (LOAD/SQUARE/COMBINE) SHALL abort the computation; ready SHALL NOT assert for the aborted operands.
REQ-026 After reset deasserts, a new computation SHALL start only on a subsequent edge with enable=1 in IDLE.
REQ-027 Outputs SHALL be undefined only before the first reset edge; benches SHALL apply reset first.

Verification
REQ-028 reset=0 for 1 edge, release, a=15, b=255, enable=1 -> ready rises on the 11th edge and x=3825.
REQ-029 From DONE, apply reset=0 -> ready=0 and x=0 on the next edge; release, a=175, b=219, enable=1 -> x=38325 with ready=1.
REQ-030 Boundary products, each run from reset:
- a=255, b=255 -> x=65025.
- a=0, b=200 -> x=0.
- a=200, b=0 -> x=0.
- a=1, b=1 -> x=1.
REQ-031 Start a=100, b=3, then change to a=7, b=9 at cycle 4; also drop enable at cycle 2 -> x=300 with ready=1.
REQ-032 Start a=50, b=60, assert reset at cycle 5 -> ready stays 0 and x=0; restart a=50, b=60 -> x=3000.
REQ-033 Hold in DONE for 20 cycles while toggling enable and a/b -> x and ready remain unchanged.

Source files
------------

// File: rtl/emul_sql_if.sv
// Operand/result bundle for emul_sql. The core keeps its flat positional port list, so this
// interface is used on the driving side to group a/b/enable with the x/ready result.
interface emul_sql_if;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        enable;
    logic [15:0] x;
    logic        ready;

    // Requester side: presents operands and start, observes the product.
    modport master (
        output a,
        output b,
        output enable,
        input  x,
        input  ready
    );

    // Multiplier side: consumes operands and start, returns the product.
    modport slave (
        input  a,
        input  b,
        input  enable,
        output x,
        output ready
    );
endinterface

// File: rtl/emul_sql.sv
// 8x8 unsigned multiplier using quarter-squares: x = ((a+b)^2 - |a-b|^2) / 4.
// Both squares are built by parallel shift-add squarers, one operand bit per cycle.
// The 9th square iteration feeds the subtract directly so that ready lands on the
// 11th edge counted from the start edge; COMBINE is then a one-cycle settle into DONE.
module emul_sql (
    output logic [15:0] x,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        clock,
    input  logic        enable,
    input  logic        reset,
    output logic        ready
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSquare,
        StCombine,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  s_q, s_d;
    logic [7:0]  d_q, d_d;
    logic [17:0] acc_s_q, acc_s_d;
    logic [15:0] acc_d_q, acc_d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] x_q, x_d;
    logic        ready_q, ready_d;

    // Next values of both squarer accumulators for the current iteration.
    logic [17:0] acc_s_step;
    logic [15:0] acc_d_step;
    logic [8:0]  d_ext;

    // One shift-add step of each squarer: add operand<<cnt when bit cnt of the operand is set.
    always_comb begin
        d_ext      = {1'b0, d_q};
        acc_s_step = acc_s_q;
        acc_d_step = acc_d_q;
        if (s_q[cnt_q]) begin
            acc_s_step = acc_s_q + ({9'd0, s_q} << cnt_q);
        end
        if (d_ext[cnt_q]) begin
            acc_d_step = acc_d_q + ({7'd0, d_ext} << cnt_q);
        end
    end

    // Next-state and datapath control; every register holds by default.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        d_d     = d_q;
        acc_s_d = acc_s_q;
        acc_d_d = acc_d_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        ready_d = ready_q;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b0;
                if (enable) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Operands are sampled only here; later changes on a/b are ignored.
                s_d     = {1'b0, a} + {1'b0, b};
                d_d     = (a >= b) ? (a - b) : (b - a);
                acc_s_d = '0;
                acc_d_d = '0;
                cnt_d   = '0;
                state_d = StSquare;
            end
            StSquare: begin
                acc_s_d = acc_s_step;
                acc_d_d = acc_d_step;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd8) begin
                    // Difference of squares is a multiple of 4, so the shift is exact.
                    x_d     = 16'((acc_s_step - {2'b00, acc_d_step}) >> 2);
                    ready_d = 1'b1;
                    state_d = StCombine;
                end
            end
            StCombine: begin
                state_d = StDone;
            end
            StDone: begin
                // Held until reset; enable and operand activity are ignored.
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset that overrides everything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            d_q     <= '0;
            acc_s_q <= '0;
            acc_d_q <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            d_q     <= d_d;
            acc_s_q <= acc_s_d;
            acc_d_q <= acc_d_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            ready_q <= ready_d;
        end
    end

    assign x     = x_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_emul_sql.sv
// Directed bench for emul_sql: a table of operand/product vectors run from reset,
// plus hand-written sequences for operand changes, mid-operation reset and DONE hold.
module tb_emul_sql;

    logic clock = 1'b0;
    logic reset = 1'b0;

    emul_sql_if bus ();

    emul_sql dut (
        .x      (bus.x),
        .a      (bus.a),
        .b      (bus.b),
        .clock  (clock),
        .enable (bus.enable),
        .reset  (reset),
        .ready  (bus.ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] x;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reset for one edge and confirm the cleared outputs.
    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b0;
        bus.enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("reset_ready", {31'd0, bus.ready}, 32'd0);
        check("reset_x", {16'd0, bus.x}, 32'd0);
        reset = 1'b1;
    endtask

    // Start an operation and count edges until ready (0 means it never rose within budget).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int drop_at,
                          input int chg_at, input logic [7:0] ca, input logic [7:0] cb,
                          output int lat, output logic [15:0] xo);
        @(negedge clock);
        bus.a      = a;
        bus.b      = b;
        bus.enable = 1'b1;
        lat        = 0;
        xo         = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (n == drop_at) bus.enable = 1'b0;
            if (n == chg_at) begin
                bus.a = ca;
                bus.b = cb;
            end
            if (bus.ready === 1'b1) begin
                lat = n;
                xo  = bus.x;
                break;
            end
        end
        bus.enable = 1'b0;
    endtask

    int          lat;
    logic [15:0] xo;
    logic [15:0] held_x;

    initial begin
        vecs[0]  = '{8'd15,  8'd255, 16'd3825};
        vecs[1]  = '{8'd175, 8'd219, 16'd38325};
        vecs[2]  = '{8'd255, 8'd255, 16'd65025};
        vecs[3]  = '{8'd0,   8'd200, 16'd0};
        vecs[4]  = '{8'd200, 8'd0,   16'd0};
        vecs[5]  = '{8'd1,   8'd1,   16'd1};
        vecs[6]  = '{8'd50,  8'd60,  16'd3000};
        vecs[7]  = '{8'd100, 8'd3,   16'd300};
        vecs[8]  = '{8'd3,   8'd100, 16'd300};
        vecs[9]  = '{8'd13,  8'd200, 16'd2600};
        vecs[10] = '{8'd128, 8'd2,   16'd256};
        vecs[11] = '{8'd200, 8'd201, 16'd40200};
        vecs[12] = '{8'd200, 8'd200, 16'd40000};

        bus.a      = '0;
        bus.b      = '0;
        bus.enable = 1'b0;

        // Table: every vector from reset, checking latency and product.
        for (int i = 0; i < 13; i++) begin
            do_reset();
            run_op(vecs[i].a, vecs[i].b, 1, 0, 8'd0, 8'd0, lat, xo);
            check($sformatf("latency_%0d", i), lat, 32'd11);
            check($sformatf("product_%0dx%0d", vecs[i].a, vecs[i].b), {16'd0, xo},
                  {16'd0, vecs[i].x});
        end

        // Reset from DONE clears outputs, then a fresh operation.
        do_reset();
        run_op(8'd175, 8'd219, 1, 0, 8'd0, 8'd0, lat, xo);
        check("seq_done_reset_x", {16'd0, xo}, 32'd38325);

        // Enable dropped after cycle 2, operands changed after cycle 4.
        do_reset();
        run_op(8'd100, 8'd3, 2, 4, 8'd7, 8'd9, lat, xo);
        check("seq_change_latency", lat, 32'd11);
        check("seq_change_x", {16'd0, xo}, 32'd300);

        // Reset asserted after cycle 5 aborts; no ready until a new enable.
        do_reset();
        @(negedge clock);
        bus.a      = 8'd50;
        bus.b      = 8'd60;
        bus.enable = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clock);
            @(negedge clock);
            bus.enable = 1'b0;
        end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(posedge clock);
            @(negedge clock);
            check("abort_ready", {31'd0, bus.ready}, 32'd0);
            check("abort_x", {16'd0, bus.x}, 32'd0);
        end
        run_op(8'd50, 8'd60, 1, 0, 8'd0, 8'd0, lat, xo);
        check("abort_restart_latency", lat, 32'd11);
        check("abort_restart_x", {16'd0, xo}, 32'd3000);

        // Hold in DONE for 20 cycles while enable and operands toggle.
        held_x = 16'd3000;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            bus.enable = n[0];
            bus.a      = 8'(n * 13 + 1);
            bus.b      = 8'(n * 7 + 3);
            @(posedge clock);
            @(negedge clock);
            check("hold_ready", {31'd0, bus.ready}, 32'd1);
            check("hold_x", {16'd0, bus.x}, {16'd0, held_x});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
